// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator processor control path:
// opcode values, sequencer state encoding and ALU operation codes.
package cpu_pkg;

  localparam int OPCODE_BITS = 4;
  localparam int ALU_OP_BITS = 3;

  // Opcodes (IR[7:4]); 4'hB..4'hE are unassigned and execute as NOP.
  localparam logic [OPCODE_BITS-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE_BITS-1:0] OP_LDA = 4'h1;
  localparam logic [OPCODE_BITS-1:0] OP_STA = 4'h2;
  localparam logic [OPCODE_BITS-1:0] OP_ADD = 4'h3;
  localparam logic [OPCODE_BITS-1:0] OP_SUB = 4'h4;
  localparam logic [OPCODE_BITS-1:0] OP_AND = 4'h5;
  localparam logic [OPCODE_BITS-1:0] OP_OR  = 4'h6;
  localparam logic [OPCODE_BITS-1:0] OP_NOT = 4'h7;
  localparam logic [OPCODE_BITS-1:0] OP_JMP = 4'h8;
  localparam logic [OPCODE_BITS-1:0] OP_JZ  = 4'h9;
  localparam logic [OPCODE_BITS-1:0] OP_JN  = 4'hA;
  localparam logic [OPCODE_BITS-1:0] OP_HLT = 4'hF;

  // ALU operation codes driven on alu_op.
  localparam logic [ALU_OP_BITS-1:0] ALU_PASS_B = 3'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_ADD    = 3'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_SUB    = 3'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_AND    = 3'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_OR     = 3'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_NOT_A  = 3'd5;

  // Sequencer states; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPERAND = 3'd2,
    EXEC_RD = 3'd3,
    EXEC_WR = 3'd4,
    HALT    = 3'd5
  } state_t;

endpackage

// File: rtl/control_unit_op_decoder.sv
// Purely combinational opcode classifier: tells the sequencer which path an
// instruction takes and which ALU operation it needs.
module op_decoder
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic                is_two_byte,
  output logic                is_jump,
  output logic                is_store,
  output logic                is_alu,
  output logic [ALU_OP_W-1:0] alu_op
);

  // Classify the opcode and pick its ALU operation.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    is_two_byte = 1'b0;
    is_jump     = 1'b0;
    is_store    = 1'b0;
    is_alu      = 1'b0;
    alu_op      = ALU_OP_W'(ALU_PASS_B);
    case (opcode)
      OPCODE_W'(OP_LDA): is_two_byte = 1'b1;
      OPCODE_W'(OP_STA): begin
        is_two_byte = 1'b1;
        is_store    = 1'b1;
      end
      OPCODE_W'(OP_ADD): begin
        is_two_byte = 1'b1;
        is_alu      = 1'b1;
        alu_op      = ALU_OP_W'(ALU_ADD);
      end
      OPCODE_W'(OP_SUB): begin
        is_two_byte = 1'b1;
        is_alu      = 1'b1;
        alu_op      = ALU_OP_W'(ALU_SUB);
      end
      OPCODE_W'(OP_AND): begin
        is_two_byte = 1'b1;
        is_alu      = 1'b1;
        alu_op      = ALU_OP_W'(ALU_AND);
      end
      OPCODE_W'(OP_OR): begin
        is_two_byte = 1'b1;
        is_alu      = 1'b1;
        alu_op      = ALU_OP_W'(ALU_OR);
      end
      OPCODE_W'(OP_NOT): alu_op = ALU_OP_W'(ALU_NOT_A);
      OPCODE_W'(OP_JMP),
      OPCODE_W'(OP_JZ),
      OPCODE_W'(OP_JN): begin
        is_two_byte = 1'b1;
        is_jump     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit accumulator processor. Fetches the
// opcode and operand bytes, decodes, and drives all datapath strobes. Every
// memory access is held until mem_ready; all outputs are Moore decodes of
// the state register qualified by mem_ready, opcode and flags.
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_z,
  input  logic                flag_n,
  input  logic                mem_ready,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic                addr_sel,
  output logic                ir_load,
  output logic                mar_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                ac_load,
  output logic                mrs_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic [2:0]          state_dbg
);

  state_t              state;
  state_t              next_state;
  logic                is_two_byte;
  logic                is_jump;
  logic                is_store;
  logic                is_alu;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                jump_taken;

  op_decoder #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_op_decoder (
    .opcode      (opcode),
    .is_two_byte (is_two_byte),
    .is_jump     (is_jump),
    .is_store    (is_store),
    .is_alu      (is_alu),
    .alu_op      (dec_alu_op)
  );

  // JMP always jumps; JZ/JN look at the flags, which are only consulted in DECODE.
  always_comb begin
    jump_taken = 1'b1;
    if (opcode == OPCODE_W'(OP_JZ)) jump_taken = flag_z;
    if (opcode == OPCODE_W'(OP_JN)) jump_taken = flag_n;
  end

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (rst) state <= FETCH;
    else     state <= next_state;
  end

  // Next-state and strobe decode; reset forces every output low at once.
  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    addr_sel   = 1'b0;
    ir_load    = 1'b0;
    mar_load   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    ac_load    = 1'b0;
    mrs_sel    = 1'b0;
    alu_op     = ALU_OP_W'(ALU_PASS_B);
    halted     = 1'b0;
    state_dbg  = state;

    case (state)
      FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        if (is_jump && !jump_taken) begin
          pc_inc     = 1'b1;          // skip the unused target byte
          next_state = FETCH;
        end else if (is_two_byte) begin
          next_state = OPERAND;
        end else if (opcode == OPCODE_W'(OP_NOT)) begin
          ac_load    = 1'b1;
          mrs_sel    = 1'b1;
          alu_op     = dec_alu_op;
          next_state = FETCH;
        end else if (opcode == OPCODE_W'(OP_HLT)) begin
          next_state = HALT;
        end else begin
          next_state = FETCH;
        end
      end

      OPERAND: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          if (is_jump) begin
            pc_load    = 1'b1;
            next_state = FETCH;
          end else begin
            mar_load   = 1'b1;
            pc_inc     = 1'b1;
            if (is_store)                              next_state = EXEC_WR;
            else if (is_alu || opcode == OPCODE_W'(OP_LDA)) next_state = EXEC_RD;
            else                                       next_state = FETCH;
          end
        end
      end

      EXEC_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        alu_op   = dec_alu_op;
        if (mem_ready) begin
          ac_load    = 1'b1;
          next_state = FETCH;
        end
      end

      EXEC_WR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        mrs_sel  = 1'b1;
        if (mem_ready) next_state = FETCH;
      end

      HALT: halted = 1'b1;

      default: next_state = FETCH;
    endcase

    if (rst) begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      addr_sel  = 1'b0;
      ir_load   = 1'b0;
      mar_load  = 1'b0;
      pc_inc    = 1'b0;
      pc_load   = 1'b0;
      ac_load   = 1'b0;
      mrs_sel   = 1'b0;
      alu_op    = ALU_OP_W'(ALU_PASS_B);
      halted    = 1'b0;
      state_dbg = 3'd0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. A tiny datapath (memory, PC, IR,
// MAR, AC) reacts to the DUT strobes; directed programs exercise the timing
// corners and random programs are compared with an instruction-level model.
module tb_control_unit;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       flag_z, flag_n, mem_ready;
  logic       mem_rd, mem_wr, addr_sel, ir_load, mar_load, pc_inc, pc_load;
  logic       ac_load, mrs_sel, halted;
  logic [2:0] alu_op;
  logic [2:0] state_dbg;

  control_unit #(.OPCODE_W(4), .ALU_OP_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .flag_z(flag_z), .flag_n(flag_n),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .ir_load(ir_load), .mar_load(mar_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .ac_load(ac_load), .mrs_sel(mrs_sel), .alu_op(alu_op), .halted(halted),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Bench-side datapath.
  logic [7:0] mem [256];
  logic [7:0] pc, ir, mar, ac;
  assign opcode = ir[7:4];
  assign flag_z = (ac == 8'h00);
  assign flag_n = ac[7];

  // Values sampled on the falling edge of the last cycle.
  logic [15:0] s_all;
  logic [8:0]  s_ctl;
  logic [4:0]  s_strb;
  logic [2:0]  s_state, s_alu;
  logic        s_rd, s_wr, s_mrs, s_halted, s_rdy;
  logic [7:0]  s_pc;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive mem_ready, sample outputs mid-cycle, then let the
  // datapath act on the strobes just after the rising edge.
  task automatic tick(input logic rdy);
    logic [7:0] addr, rdata, b, res, wdata;
    mem_ready = rdy;
    @(negedge clk);
    s_rd = mem_rd; s_wr = mem_wr; s_mrs = mrs_sel; s_halted = halted;
    s_state = state_dbg; s_alu = alu_op; s_rdy = rdy; s_pc = pc;
    s_strb = {ir_load, mar_load, pc_inc, pc_load, ac_load};
    s_ctl  = {mem_rd, mem_wr, addr_sel, s_strb, mrs_sel};
    s_all  = {s_ctl, alu_op, halted, state_dbg};
    addr  = addr_sel ? mar : pc;
    rdata = mem[addr];
    b     = mrs_sel ? ac : rdata;
    wdata = ac;
    case (alu_op)
      3'd1:    res = ac + b;
      3'd2:    res = ac - b;
      3'd3:    res = ac & b;
      3'd4:    res = ac | b;
      3'd5:    res = ~ac;
      default: res = b;
    endcase
    if ((s_rd || s_wr) && !rdy) check("wait_quiet", 32'(s_strb), 0);
    if (s_rd && s_wr) check("rd_wr_excl", 32'({s_rd, s_wr}), 32'b10);
    @(posedge clk);
    #1;
    if (s_strb[4]) ir = rdata;
    if (s_strb[3]) mar = rdata;
    if (s_strb[1]) pc = rdata;
    else if (s_strb[2]) pc = pc + 8'd1;
    if (s_strb[0]) ac = res;
    if (s_wr && rdy) mem[addr] = wdata;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b1);
    check("rst_outputs", 32'(s_all), 0);
    tick(1'b0);
    check("rst_outputs_idle", 32'(s_all), 0);
    rst = 1'b0;
    pc  = 8'h00;
  endtask

  // Instruction-level reference model state.
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_ac;
  logic       m_halt;
  int         exp_acc;

  // Execute the instruction at m_pc architecturally; returns the number of
  // completed memory accesses it should take (opcode fetch included).
  task automatic model_exec();
    logic [7:0] opb, opnd;
    logic [3:0] op;
    opb  = m_mem[m_pc];
    op   = opb[7:4];
    opnd = m_mem[8'(m_pc + 8'd1)];
    exp_acc = 1;
    case (op)
      4'h1: begin m_ac = m_mem[opnd]; m_pc = m_pc + 8'd2; exp_acc = 3; end
      4'h2: begin m_mem[opnd] = m_ac; m_pc = m_pc + 8'd2; exp_acc = 3; end
      4'h3: begin m_ac = m_ac + m_mem[opnd]; m_pc = m_pc + 8'd2; exp_acc = 3; end
      4'h4: begin m_ac = m_ac - m_mem[opnd]; m_pc = m_pc + 8'd2; exp_acc = 3; end
      4'h5: begin m_ac = m_ac & m_mem[opnd]; m_pc = m_pc + 8'd2; exp_acc = 3; end
      4'h6: begin m_ac = m_ac | m_mem[opnd]; m_pc = m_pc + 8'd2; exp_acc = 3; end
      4'h7: begin m_ac = ~m_ac; m_pc = m_pc + 8'd1; end
      4'h8, 4'h9, 4'hA: begin
        if (op == 4'h8 || (op == 4'h9 && m_ac == 8'h00) || (op == 4'hA && m_ac[7])) begin
          m_pc = opnd; exp_acc = 2;
        end else begin
          m_pc = m_pc + 8'd2;
        end
      end
      4'hF: m_halt = 1'b1;
      default: m_pc = m_pc + 8'd1;
    endcase
  endtask

  task automatic random_program(input int max_instr, output int done);
    int  acc, idle, budget;
    bit  have_prev, mem_ok;
    done = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      if ($urandom_range(0, 9) == 0) mem[i][7:4] = 4'hF;     // occasional HLT
      else if (mem[i][7:4] == 4'hF) mem[i][7:4] = 4'h3;
    end
    ac = 8'($urandom);
    if ($urandom_range(0, 3) == 0) ac = 8'h00;
    do_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    m_pc = 8'h00; m_ac = ac; m_halt = 1'b0;
    have_prev = 0; acc = 0; idle = 0; budget = 0;
    while (!m_halt && done < max_instr && budget < 3000) begin
      tick(($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
      budget++;
      if (s_strb[4]) begin
        if (have_prev) begin
          check("rnd_accesses", 32'(acc), 32'(exp_acc));
          check("rnd_decode_cycles", 32'(idle), 1);
        end
        check("rnd_pc", 32'(s_pc), 32'(m_pc));
        check("rnd_ac", 32'(ac), 32'(m_ac));
        mem_ok = 1;
        for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) mem_ok = 0;
        check("rnd_mem", 32'(mem_ok), 1);
        model_exec();
        have_prev = 1; acc = 0; idle = 0; done++;
      end
      if ((s_rd || s_wr) && s_rdy) acc++;
      if (!(s_rd || s_wr)) idle++;
    end
    if (m_halt) begin
      for (int k = 0; k < 4; k++) tick(1'b1);
      check("rnd_halted", 32'({s_halted, s_state}), 32'({1'b1, 3'd5}));
    end
    check("rnd_progress", 32'(done > 0), 1);
  endtask

  initial begin
    int pcnt, total;
    rst = 1'b1; mem_ready = 1'b0;
    pc = 8'h00; ir = 8'h00; mar = 8'h00; ac = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h80; mem[8'h80] = 8'h5A;  // LDA 80
    mem[8'h02] = 8'h20; mem[8'h03] = 8'h90;                      // STA 90
    mem[8'h04] = 8'h40; mem[8'h05] = 8'h80;                      // SUB 80
    mem[8'h06] = 8'h90; mem[8'h07] = 8'h20;                      // JZ 20
    mem[8'h20] = 8'h70;                                          // NOT
    mem[8'h21] = 8'h90; mem[8'h22] = 8'h00;                      // JZ 00
    mem[8'h23] = 8'h10; mem[8'h24] = 8'h80;                      // LDA 80
    mem[8'h30] = 8'hF0;                                          // HLT
    do_reset();

    // LDA, zero wait: FETCH DECODE OPERAND EXEC_RD FETCH.
    for (int i = 0; i < 5; i++) begin
      tick(1'b1);
      check("lda_state", 32'(s_state), (i == 4) ? 0 : 32'(i));
      if (i == 0) check("lda_first_rd", 32'(s_rd), 1);
      if (i == 3) check("lda_acload", 32'({s_strb[0], s_mrs, s_alu}), 32'({1'b1, 1'b0, 3'd0}));
    end
    check("lda_ac", 32'(ac), 32'h5A);

    // STA with three wait cycles in EXEC_WR (its FETCH was the last tick).
    tick(1'b1); tick(1'b1);
    for (int i = 0; i < 4; i++) begin
      tick((i == 3) ? 1'b1 : 1'b0);
      check("sta_wr_mrs", 32'({s_wr, s_mrs, s_state}), 32'({1'b1, 1'b1, 3'd4}));
      if (i < 3) check("sta_wait_strobes", 32'(s_strb), 0);
    end
    tick(1'b1);
    check("sta_then_fetch", 32'(s_state), 0);
    check("sta_mem", 32'(mem[8'h90]), 32'h5A);

    // SUB brings AC to zero.
    tick(1'b1); tick(1'b1); tick(1'b1);
    check("sub_ac", 32'(ac), 0);

    // JZ taken: pc_load in cycle 3, a single pc_inc.
    pcnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      pcnt += int'(s_strb[2]);
      if (i == 2) check("jz_taken_pcload", 32'(s_strb[1]), 1);
    end
    check("jz_taken_pcinc", 32'(pcnt), 1);
    check("jz_taken_pc", 32'(pc), 32'h20);

    // NOT: everything happens in DECODE, 2 cycles in total.
    tick(1'b1);
    tick(1'b1);
    check("not_decode", 32'({s_state, s_strb[0], s_mrs, s_alu}), 32'({3'd1, 1'b1, 1'b1, 3'd5}));
    check("not_ac", 32'(ac), 32'hFF);

    // JZ not taken: pc_inc in FETCH and DECODE, back to FETCH after 2 cycles.
    pcnt = 0;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1);
      pcnt += int'(s_strb[2]);
    end
    check("jz_nt_pcinc", 32'(pcnt), 2);
    tick(1'b1);
    check("jz_nt_fetch", 32'(s_state), 0);
    check("jz_nt_pc", 32'(s_pc), 32'h23);

    // LDA aborted by reset in an EXEC_RD wait.
    tick(1'b1); tick(1'b1); tick(1'b0);
    check("abort_wait_rd", 32'({s_rd, s_state}), 32'({1'b1, 3'd3}));
    rst = 1'b1;
    tick(1'b1);
    check("abort_rd_drop", 32'({s_rd, s_strb}), 0);
    tick(1'b1);
    rst = 1'b0;
    check("abort_no_acload", 32'(ac), 32'hFF);
    pc = 8'h30;
    tick(1'b1);
    check("abort_fetch", 32'({s_rd, s_state}), 32'({1'b1, 3'd0}));

    // HLT: parked with all strobes low while mem_ready toggles.
    tick(1'b1); tick(1'b1);
    for (int i = 0; i < 10; i++) begin
      tick(1'(i));
      check("halt_state", 32'({s_halted, s_state}), 32'({1'b1, 3'd5}));
      check("halt_quiet", 32'(s_ctl), 0);
    end
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    tick(1'b1);
    check("halt_exit", 32'({s_halted, s_state, s_rd}), 32'({1'b0, 3'd0, 1'b1}));

    // Random programs against the instruction-level model.
    total = 0;
    for (int p = 0; p < 6; p++) begin
      int done;
      random_program(120, done);
      total += done;
    end
    check("rnd_total", 32'(total >= 20), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit accumulator processor. It fetches instructions and operands, decodes the 4-bit opcode and drives every datapath strobe: PC, IR, MAR, AC load, memory read/write, ALU op, and the `mrs_sel` select of the `mrs` AC/memory operand mux. Each memory access waits on a `mem_ready` handshake, so slow memories insert wait states without datapath changes.

## Interface
- `OPCODE_W`, default 4: opcode width, taken from IR[7:4].
- `ALU_OP_W`, default 3: width of the ALU operation code.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `opcode` in OPCODE_W: IR[7:4], stable from DECODE onward.
- `flag_z` in 1: AC == 0, from the datapath.
- `flag_n` in 1: AC[7], from the datapath.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_rd` out 1: memory read request.
- `mem_wr` out 1: memory write request; the data bus carries the AC.
- `addr_sel` out 1: 0 = PC drives the address, 1 = MAR drives it.
- `ir_load` out 1: IR <= mem data.
- `mar_load` out 1: MAR <= mem data.
- `pc_inc` out 1: PC <= PC + 1, wraps 8'hFF -> 8'h00.
- `pc_load` out 1: PC <= mem data (jump target).
- `ac_load` out 1: AC <= ALU result.
- `mrs_sel` out 1: `mrs` choice; 1 = AC, 0 = memory data.
- `alu_op` out ALU_OP_W: 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 NOT_A.
- `halted` out 1: high in HALT.
- `state_dbg` out 3: current state encoding.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LDA a: AC <= M[a].
  - 2 STA a: M[a] <= AC.
  - 3 ADD a, 4 SUB a, 5 AND a, 6 OR a: AC <= AC op M[a].
  - 7 NOT: AC <= ~AC.
  - 8 JMP t.
  - 9 JZ t: jump if `flag_z`.
  - A JN t: jump if `flag_n`.
  - F HLT.
  - B–E: treated as NOP.
- Instructions 1–6 and 8–A are two bytes: the opcode byte, then the operand byte at PC+1.
- States:
  - FETCH: `mem_rd`, `addr_sel`=0. On `mem_ready`: `ir_load`, `pc_inc`, go to DECODE.
  - DECODE: no strobes.
    - NOP, B–E: go to FETCH.
    - NOT: `ac_load`, `mrs_sel`=1, `alu_op`=NOT_A, go to FETCH.
    - HLT: go to HALT.
    - JZ or JN with the condition false: `pc_inc` (skip the operand byte), go to FETCH.
    - Otherwise: go to OPERAND.
  - OPERAND: `mem_rd`, `addr_sel`=0. On `mem_ready`:
    - Jumps: `pc_load`, go to FETCH.
    - All others: `mar_load`, `pc_inc`, go to EXEC_RD (LDA, ALU ops) or EXEC_WR (STA).
  - EXEC_RD: `mem_rd`, `addr_sel`=1, `mrs_sel`=0. On `mem_ready`: `ac_load` with `alu_op`=PASS_B (LDA) or the matching op, go to FETCH.
  - EXEC_WR: `mem_wr`, `addr_sel`=1, `mrs_sel`=1. On `mem_ready`: go to FETCH.
  - HALT: all strobes 0, `halted`=1. Left only by `rst`.
- Jump condition is sampled from `flag_z`/`flag_n` in DECODE.
- Load strobes (`ir_load`, `mar_load`, `pc_inc`, `pc_load`, `ac_load`) are single-cycle pulses. They are asserted only in the cycle where `mem_ready`=1 (or in DECODE as listed above).
- `mem_rd`/`mem_wr` are level requests held for the whole wait.
- `mem_ready` is ignored in DECODE and HALT.

## Timing
- Reset: while `rst`=1, all outputs are 0, `alu_op`=0, `state_dbg`=0. State <= FETCH on the edge.
- First cycle after `rst` falls: FETCH with `mem_rd`=1.
- Zero-wait latency:
  - NOP/NOT/HLT: 2 cycles.
  - Jump taken: 3 cycles.
  - Jump not taken: 2 cycles.
  - LDA/STA/ALU ops: 4 cycles.
- Each wait cycle (`mem_ready`=0) adds 1 cycle; there is no timeout.
- `rst` asserted mid-access aborts it: `mem_rd`/`mem_wr` drop in the same cycle (combinational gating) and no strobe fires.
- Outputs are Moore decodes of the state register, qualified only by `mem_ready` and `opcode`/flags. No output is registered.
- Any undefined state encoding goes to FETCH on the next edge.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode localparams (OP_NOP … OP_HLT);
  - state encoding (FETCH=0, DECODE=1, OPERAND=2, EXEC_RD=3, EXEC_WR=4, HALT=5);
  - ALU op codes.
- One combinational sub-module, `op_decoder`, maps `opcode` to the class flags `is_two_byte`, `is_jump`, `is_store`, `is_alu` and to `alu_op`.
- The FSM lives in `control_unit`.

## Test plan
- Reset, then `opcode`=1, `mem_ready` tied 1. Required:
  - states FETCH, DECODE, OPERAND, EXEC_RD, FETCH;
  - `ac_load`=1 with `mrs_sel`=0 and `alu_op`=0 in cycle 4.
- STA with `mem_ready` low for 3 cycles in EXEC_WR. Required:
  - `mem_wr`=1 and `mrs_sel`=1 held for 4 cycles;
  - no strobes during the wait;
  - FETCH follows.
- JZ:
  - `flag_z`=1: `pc_load` in cycle 3, `pc_inc` only once in total.
  - `flag_z`=0: `pc_inc` in FETCH and again in DECODE, back to FETCH after 2 cycles.
- `opcode`=F. Required: HALT entered, `halted`=1, all strobes 0 for 10 cycles while `mem_ready` toggles. `rst` then returns the unit to FETCH.
- `rst` pulsed during an EXEC_RD wait. Required: `mem_rd` drops in the same cycle, no `ac_load` pulse, FETCH after release.
- `opcode`=7 (NOT). Required: `ac_load`, `mrs_sel`=1, `alu_op`=5 in DECODE, total 2 cycles.
